// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcode encodings,
// sequencer state encoding and datapath field widths.
package cpu_pkg;

  localparam int INSTR_W    = 9;
  localparam int REG_ADDR_W = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED,
    ST_FAULT,
    ST_PAUSE
  } state_t;

  // True when the decoded opcode stops the sequencer for good.
  function automatic logic isHalt(input logic [2:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Instruction-memory fetch bus: the control unit is the master, issuing
// imem_req/imem_addr and holding them until the memory answers with imem_ack.
interface cpu_control_unit_if #(
  parameter int PC_WIDTH = 8
);
  import cpu_pkg::*;

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/cpu_fetch_timer.sv
// Counts FETCH cycles that pass without an acknowledge and flags the cycle in
// which the memory has run out of time. An ack in that same cycle suppresses
// the timeout, so a late-but-in-time answer still completes the fetch.
module cpu_fetch_timer #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inFetch,
  input  logic i_ack,
  output logic o_timeout
);

  localparam logic [7:0] LAST_WAIT = 8'(FETCH_TIMEOUT - 1);

  logic [7:0] r_waitCnt;
  logic       w_waiting;

  assign w_waiting = i_inFetch && !i_ack;
  assign o_timeout = w_waiting && (r_waitCnt == LAST_WAIT);

  // Count unanswered FETCH cycles; clear whenever FETCH is left or answered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (w_waiting && !o_timeout) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end else begin
      r_waitCnt <= '0;
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the 8-bit CPU: FETCH -> DECODE -> EXECUTE ->
// WRITEBACK, owning pc, zero flag, halt/fault status and the retired count.
// Optional feature macro: CPU_SINGLE_STEP_EN adds a 'step' input and a PAUSE
// state between instructions.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH      = 8,
  parameter int RESET_PC      = 0,
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
`ifdef CPU_SINGLE_STEP_EN
  input  logic                  step,
`endif
  cpu_control_unit_if.master    imem,
  output logic [INSTR_W-1:0]    dec_instr,
  input  logic [2:0]            dec_opcode,
  input  logic [REG_ADDR_W-1:0] dec_dest,
  input  logic [REG_ADDR_W-1:0] dec_src,
  output logic [REG_ADDR_W-1:0] rf_ra,
  output logic [REG_ADDR_W-1:0] rf_rb,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wa,
  output logic [2:0]            alu_op,
  output logic                  alu_en,
  input  logic                  alu_zero,
  output logic                  zero_flag,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  halted,
  output logic                  fault,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  state_t                r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [INSTR_W-1:0]    r_ir;
  logic [2:0]            r_opcode;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [REG_ADDR_W-1:0] r_src;
  logic                  r_zeroFlag;
  logic                  r_halted;
  logic                  r_fault;
  logic [CNT_WIDTH-1:0]  r_instrCount;
  logic                  r_imemReq;
  logic                  r_aluEn;
  logic                  r_rfWe;
  logic                  w_inFetch;
  logic                  w_timeout;

  assign w_inFetch = (r_state == ST_FETCH);

  cpu_fetch_timer #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetchTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inFetch (w_inFetch),
    .i_ack     (imem.imem_ack),
    .o_timeout (w_timeout)
  );

  assign imem.imem_req  = r_imemReq;
  assign imem.imem_addr = r_pc;
  assign dec_instr      = r_ir;
  assign rf_ra          = r_dest;
  assign rf_rb          = r_src;
  assign rf_wa          = r_dest;
  assign alu_op         = r_opcode;
  assign alu_en         = r_aluEn;
  assign rf_we          = r_rfWe;
  assign zero_flag      = r_zeroFlag;
  assign pc             = r_pc;
  assign halted         = r_halted;
  assign fault          = r_fault;
  assign instr_count    = r_instrCount;

  // Sequencer; each strobe is raised on the edge that enters its state so it
  // is high for exactly the cycle spent there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= PC_WIDTH'(RESET_PC);
      r_ir         <= '0;
      r_opcode     <= '0;
      r_dest       <= '0;
      r_src        <= '0;
      r_zeroFlag   <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_instrCount <= '0;
      r_imemReq    <= 1'b0;
      r_aluEn      <= 1'b0;
      r_rfWe       <= 1'b0;
    end else begin
      r_imemReq <= 1'b0;
      r_aluEn   <= 1'b0;
      r_rfWe    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state   <= ST_FETCH;
            r_imemReq <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem.imem_ack) begin
            r_ir    <= imem.imem_rdata;
            r_state <= ST_DECODE;
          end else if (w_timeout) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_imemReq <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_opcode <= dec_opcode;
          r_dest   <= dec_dest;
          r_src    <= dec_src;
          if (isHalt(dec_opcode)) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_state <= ST_EXECUTE;
            r_aluEn <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          r_state <= ST_WRITEBACK;
          r_rfWe  <= 1'b1;
        end
        ST_WRITEBACK: begin
          r_zeroFlag   <= alu_zero;
          r_pc         <= r_pc + 1'b1;
          r_instrCount <= r_instrCount + 1'b1;
          if (run) begin
`ifdef CPU_SINGLE_STEP_EN
            r_state   <= ST_PAUSE;
`else
            r_state   <= ST_FETCH;
            r_imemReq <= 1'b1;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
`ifdef CPU_SINGLE_STEP_EN
        ST_PAUSE: begin
          if (!run) begin
            r_state <= ST_IDLE;
          end else if (step) begin
            r_state   <= ST_FETCH;
            r_imemReq <= 1'b1;
          end
        end
`endif
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: a small instruction memory answers the
// fetch bus after a programmable number of wait cycles, and a combinational
// decoder splits dec_instr into its fields.
module tb_cpu_control_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
`ifdef CPU_SINGLE_STEP_EN
  logic        stepIn;
`endif
  logic [8:0]  decInstr;
  logic [2:0]  decOpcode;
  logic [2:0]  decDest;
  logic [2:0]  decSrc;
  logic [2:0]  rfRa;
  logic [2:0]  rfRb;
  logic        rfWe;
  logic [2:0]  rfWa;
  logic [2:0]  aluOp;
  logic        aluEn;
  logic        aluZero;
  logic        zeroFlag;
  logic [7:0]  pcOut;
  logic        haltedOut;
  logic        faultOut;
  logic [15:0] instrCount;

  logic [8:0]  tbMem [256];
  int          ackDelay;
  logic        ackEnable;
  int          tbWait;
  int          compareCount;
  int          mismatchCount;

  cpu_control_unit_if #(.PC_WIDTH(8)) imemBus ();

  cpu_control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
`ifdef CPU_SINGLE_STEP_EN
    .step        (stepIn),
`endif
    .imem        (imemBus),
    .dec_instr   (decInstr),
    .dec_opcode  (decOpcode),
    .dec_dest    (decDest),
    .dec_src     (decSrc),
    .rf_ra       (rfRa),
    .rf_rb       (rfRb),
    .rf_we       (rfWe),
    .rf_wa       (rfWa),
    .alu_op      (aluOp),
    .alu_en      (aluEn),
    .alu_zero    (aluZero),
    .zero_flag   (zeroFlag),
    .pc          (pcOut),
    .halted      (haltedOut),
    .fault       (faultOut),
    .instr_count (instrCount)
  );

  // Field split of the instruction word, standing in for the real decoder.
  assign decOpcode = decInstr[8:6];
  assign decDest   = decInstr[5:3];
  assign decSrc    = decInstr[2:0];

  // Memory answers once the request has waited ackDelay cycles.
  assign imemBus.imem_ack   = imemBus.imem_req && ackEnable && (tbWait >= ackDelay);
  assign imemBus.imem_rdata = tbMem[imemBus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Track how long the current request has gone unanswered.
  always @(posedge clk) begin
    if (imemBus.imem_req && !imemBus.imem_ack) tbWait <= tbWait + 1;
    else tbWait <= 0;
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitFetchAt(input string tag, input logic [7:0] target);
    int n;
    n = 0;
    while (!(imemBus.imem_req === 1'b1 && pcOut === target) && n < 3000) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(tag, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    tbWait        = 0;
    ackDelay      = 0;
    ackEnable     = 1'b1;
    aluZero       = 1'b0;
    run           = 1'b0;
    rst_n         = 1'b0;
`ifdef CPU_SINGLE_STEP_EN
    stepIn        = 1'b1;
`endif
    for (int i = 0; i < 256; i++) begin
      tbMem[i][8:6] = 3'(i % 7);
      tbMem[i][5:0] = 6'(i);
    end
    tbMem[0] = 9'b000_001_010;
    tbMem[1] = 9'b011_010_011;

    // Reset state
    applyStimulus(2);
    checkOutput("rst_req", 32'(imemBus.imem_req), 32'd0);
    checkOutput("rst_pc", 32'(pcOut), 32'd0);
    checkOutput("rst_ir", 32'(decInstr), 32'd0);
    checkOutput("rst_flags", {28'd0, zeroFlag, haltedOut, faultOut, rfWe}, 32'd0);
    checkOutput("rst_count", 32'(instrCount), 32'd0);
    checkOutput("rst_alu_en", 32'(aluEn), 32'd0);
    rst_n = 1'b1;

    // ADD r1,r2 with zero-wait ack
    run = 1'b1;
    applyStimulus(1);
    checkOutput("t1_fetch_req", 32'(imemBus.imem_req), 32'd1);
    checkOutput("t1_fetch_addr", 32'(imemBus.imem_addr), 32'd0);
    applyStimulus(1);
    checkOutput("t1_dec_instr", 32'(decInstr), 32'h00A);
    checkOutput("t1_dec_req", 32'(imemBus.imem_req), 32'd0);
    applyStimulus(1);
    checkOutput("t1_ex_alu_en", 32'(aluEn), 32'd1);
    checkOutput("t1_ex_ops", {20'd0, 1'b0, aluOp, 1'b0, rfRa, 1'b0, rfRb}, {20'd0, 12'h012});
    aluZero = 1'b1;
    applyStimulus(1);
    checkOutput("t1_wb_we", 32'(rfWe), 32'd1);
    checkOutput("t1_wb_wa", 32'(rfWa), 32'd1);
    checkOutput("t1_wb_alu_en", 32'(aluEn), 32'd0);
    run = 1'b0;
    applyStimulus(1);
    checkOutput("t1_pc", 32'(pcOut), 32'd1);
    checkOutput("t1_count", 32'(instrCount), 32'd1);
    checkOutput("t1_zero", 32'(zeroFlag), 32'd1);
    checkOutput("t1_idle_we", 32'(rfWe), 32'd0);

    // OR r2,r3 with the ack held back three cycles; run drops in EXECUTE
    ackDelay = 3;
    aluZero  = 1'b0;
    run      = 1'b1;
    applyStimulus(1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_req_held", 32'(imemBus.imem_req), 32'd1);
      checkOutput("t2_addr_stable", 32'(imemBus.imem_addr), 32'd1);
      applyStimulus(1);
    end
    checkOutput("t2_dec_req", 32'(imemBus.imem_req), 32'd0);
    checkOutput("t2_dec_instr", 32'(decInstr), 32'h0D3);
    applyStimulus(1);
    checkOutput("t2_ex_ops", {20'd0, 1'b0, aluOp, 1'b0, rfRa, 1'b0, rfRb}, {20'd0, 12'h323});
    run = 1'b0;
    applyStimulus(1);
    checkOutput("t2_wb_cycle7", 32'(rfWe), 32'd1);
    checkOutput("t2_wb_wa", 32'(rfWa), 32'd2);
    applyStimulus(1);
    checkOutput("t2_pc", 32'(pcOut), 32'd2);
    checkOutput("t2_count", 32'(instrCount), 32'd2);
    checkOutput("t2_zero", 32'(zeroFlag), 32'd0);
    checkOutput("t2_idle_req", 32'(imemBus.imem_req), 32'd0);

    // No ack at all: fault after the 15th FETCH cycle
    ackEnable = 1'b0;
    ackDelay  = 0;
    run       = 1'b1;
    applyStimulus(15);
    checkOutput("t3_c15_fault", 32'(faultOut), 32'd0);
    checkOutput("t3_c15_req", 32'(imemBus.imem_req), 32'd1);
    applyStimulus(1);
    checkOutput("t3_fault", 32'(faultOut), 32'd1);
    checkOutput("t3_req_low", 32'(imemBus.imem_req), 32'd0);
    checkOutput("t3_pc_held", 32'(pcOut), 32'd2);
    checkOutput("t3_no_we", 32'(rfWe), 32'd0);
    run = 1'b0;
    applyStimulus(3);
    run = 1'b1;
    applyStimulus(3);
    checkOutput("t3_fault_sticky", 32'(faultOut), 32'd1);
    checkOutput("t3_count", 32'(instrCount), 32'd2);

    // Reset clears fault; reset mid-fetch drops the request at once
    rst_n = 1'b0;
    applyStimulus(1);
    rst_n = 1'b1;
    checkOutput("t4_fault_cleared", 32'(faultOut), 32'd0);
    checkOutput("t4_pc_reset", 32'(pcOut), 32'd0);
    applyStimulus(1);
    checkOutput("t4_req_before_rst", 32'(imemBus.imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t4_async_req_drop", 32'(imemBus.imem_req), 32'd0);
    applyStimulus(1);
    rst_n = 1'b1;

    // Ack on exactly the 15th FETCH cycle wins over the timeout
    ackEnable = 1'b1;
    ackDelay  = 14;
    applyStimulus(15);
    checkOutput("t4_c15_req", 32'(imemBus.imem_req), 32'd1);
    applyStimulus(1);
    checkOutput("t4_no_fault", 32'(faultOut), 32'd0);
    checkOutput("t4_dec_instr", 32'(decInstr), 32'h00A);

    // HALT fetched from pc=5
    ackDelay = 0;
    tbMem[5] = 9'b111_000_000;
    waitFetchAt("t5_reach_pc5", 8'd5);
    checkOutput("t5_count_before", 32'(instrCount), 32'd5);
    applyStimulus(2);
    checkOutput("t5_halted", 32'(haltedOut), 32'd1);
    checkOutput("t5_pc", 32'(pcOut), 32'd5);
    checkOutput("t5_count", 32'(instrCount), 32'd5);
    checkOutput("t5_alu_en", 32'(aluEn), 32'd0);
    run = 1'b0;
    applyStimulus(2);
    run = 1'b1;
    applyStimulus(3);
    checkOutput("t5_still_halted", 32'(haltedOut), 32'd1);
    checkOutput("t5_pc_after_run", 32'(pcOut), 32'd5);
    checkOutput("t5_req_after_run", 32'(imemBus.imem_req), 32'd0);

    // pc wrap at 255 with run dropped during EXECUTE
    tbMem[5] = 9'b000_101_110;
    rst_n = 1'b0;
    applyStimulus(1);
    rst_n = 1'b1;
    waitFetchAt("t6_reach_pc255", 8'd255);
    checkOutput("t6_count_before", 32'(instrCount), 32'd255);
    applyStimulus(2);
    run = 1'b0;
    applyStimulus(1);
    checkOutput("t6_wb_we", 32'(rfWe), 32'd1);
    applyStimulus(1);
    checkOutput("t6_pc_wrap", 32'(pcOut), 32'd0);
    checkOutput("t6_count", 32'(instrCount), 32'd256);
    checkOutput("t6_idle_req", 32'(imemBus.imem_req), 32'd0);
    applyStimulus(2);
    checkOutput("t6_stays_idle", 32'(imemBus.imem_req), 32'd0);

`ifdef CPU_SINGLE_STEP_EN
    // Single-step: PAUSE after writeback until step is pulsed
    stepIn = 1'b0;
    run    = 1'b1;
    applyStimulus(5);
    checkOutput("t7_pause_req", 32'(imemBus.imem_req), 32'd0);
    checkOutput("t7_pause_pc", 32'(pcOut), 32'd1);
    applyStimulus(2);
    checkOutput("t7_pause_hold", 32'(imemBus.imem_req), 32'd0);
    stepIn = 1'b1;
    applyStimulus(1);
    stepIn = 1'b0;
    checkOutput("t7_step_req", 32'(imemBus.imem_req), 32'd1);
    checkOutput("t7_step_addr", 32'(imemBus.imem_addr), 32'd1);
    run = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
